// File: rtl/clock_pkg.sv
// rtl/clock_pkg.sv - shared time-of-day constants, HHMM word type and validity check
// Purpose: common definitions for the timekeeper, alarm and display blocks.
// Contents:
//   HOUR_MAX, MIN_MAX, SEC_MAX  - last BCD value of each field before it wraps to 00
//   TIME_RESET                  - HHMM value held after reset
//   hhmm_t                      - 16-bit BCD HHMM word
//   hhmm_valid()                - 1 when the word is all-BCD, HH <= 23 and MM <= 59
package clock_pkg;

  localparam logic [7:0]  HOUR_MAX   = 8'h23;
  localparam logic [7:0]  MIN_MAX    = 8'h59;
  localparam logic [7:0]  SEC_MAX    = 8'h59;
  localparam logic [15:0] TIME_RESET = 16'h0000;

  typedef logic [15:0] hhmm_t;

  function automatic logic hhmm_valid(input hhmm_t t);
    logic digits_ok;
    digits_ok = (t[15:12] <= 4'h9) && (t[11:8] <= 4'h9) &&
                (t[7:4]   <= 4'h9) && (t[3:0]  <= 4'h9);
    // With every nibble a BCD digit, a plain numeric compare orders the values correctly.
    return digits_ok && (t[15:8] <= HOUR_MAX) && (t[7:0] <= MIN_MAX);
  endfunction

endpackage

// File: rtl/bcd2_counter.sv
// rtl/bcd2_counter.sv - two-digit BCD counter that wraps MAX -> 00
// Purpose: one time field (seconds, minutes or hours).
// Ports:
//   clk, rst       - clock, synchronous active-low reset (clears to 00)
//   inc            - advance by one this edge
//   load, load_val - overwrite with load_val (wins over inc)
//   val            - registered BCD value
//   wrap           - combinational: inc && val == MAX, the carry into the next field
module bcd2_counter
  import clock_pkg::*;
#(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       inc,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] val,
  output logic       wrap
);

  logic [7:0] r_val;
  logic [7:0] w_next;

  always_comb begin
    w_next = r_val;
    if (r_val == MAX) begin
      w_next = 8'h00;
    end else if (r_val[3:0] == 4'h9) begin
      w_next = {r_val[7:4] + 4'h1, 4'h0};
    end else begin
      w_next = {r_val[7:4], r_val[3:0] + 4'h1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_val <= 8'h00;
    end else if (load) begin
      r_val <= load_val;
    end else if (inc) begin
      r_val <= w_next;
    end
  end

  assign val  = r_val;
  assign wrap = inc && (r_val == MAX);

endmodule

// File: rtl/bcd_timekeeper.sv
// rtl/bcd_timekeeper.sv - free-running 24-hour BCD time-of-day counter
// Purpose: prescaled 1 s tick, BCD seconds/minutes/hours with load and set buttons.
// Ports:
//   clk, rst             - clock, synchronous active-low reset
//   run                  - 1 = prescaler and seconds advance
//   load, load_time      - load BCD HHMM (rejected if out of range)
//   inc_min, inc_hour    - set-button increments, no carry into the next field
//   cur_time, cur_sec    - registered BCD HHMM and seconds
//   sec_pulse, min_pulse, day_pulse - one-cycle rollover strobes
//   load_err             - one-cycle strobe for a rejected load
module bcd_timekeeper
  import clock_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic        load,
  input  logic [15:0] load_time,
  input  logic        inc_min,
  input  logic        inc_hour,
  output logic [15:0] cur_time,
  output logic [7:0]  cur_sec,
  output logic        sec_pulse,
  output logic        min_pulse,
  output logic        day_pulse,
  output logic        load_err
);

  localparam int PW = $clog2(TICKS_PER_SEC);

  logic [PW-1:0] r_presc;
  logic          r_sec_pulse;
  logic          r_min_pulse;
  logic          r_day_pulse;
  logic          r_load_err;

  logic       w_tick;
  logic       w_load_ok;
  logic       w_sec_wrap;
  logic       w_min_wrap;
  logic       w_hour_wrap;
  logic       w_min_inc;
  logic       w_hour_carry;
  logic       w_hour_inc;
  logic [7:0] w_sec_val;
  logic [7:0] w_min_val;
  logic [7:0] w_hour_val;

  assign w_tick    = run && (r_presc == PW'(TICKS_PER_SEC - 1));
  assign w_load_ok = load && hhmm_valid(load_time);

  // A set-button press replaces the natural carry into its field rather than adding to it.
  assign w_min_inc    = !w_load_ok && (inc_min || w_sec_wrap);
  assign w_hour_carry = w_min_wrap && !inc_min;
  assign w_hour_inc   = !w_load_ok && (inc_hour || w_hour_carry);

  bcd2_counter #(.MAX(SEC_MAX)) u_sec (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_tick && !w_load_ok),
    .load     (w_load_ok),
    .load_val (8'h00),
    .val      (w_sec_val),
    .wrap     (w_sec_wrap)
  );

  bcd2_counter #(.MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_min_inc),
    .load     (w_load_ok),
    .load_val (load_time[7:0]),
    .val      (w_min_val),
    .wrap     (w_min_wrap)
  );

  bcd2_counter #(.MAX(HOUR_MAX)) u_hour (
    .clk      (clk),
    .rst      (rst),
    .inc      (w_hour_inc),
    .load     (w_load_ok),
    .load_val (load_time[15:8]),
    .val      (w_hour_val),
    .wrap     (w_hour_wrap)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_presc     <= '0;
      r_sec_pulse <= 1'b0;
      r_min_pulse <= 1'b0;
      r_day_pulse <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      if (w_load_ok || w_tick) begin
        r_presc <= '0;
      end else if (run) begin
        r_presc <= r_presc + PW'(1);
      end
      r_sec_pulse <= w_tick && !w_load_ok;
      r_min_pulse <= w_sec_wrap;
      // Only a natural ripple out of 23 marks a new day; a set-button wrap does not.
      r_day_pulse <= w_hour_wrap && !inc_hour;
      r_load_err  <= load && !w_load_ok;
    end
  end

  assign cur_time  = {w_hour_val, w_min_val};
  assign cur_sec   = w_sec_val;
  assign sec_pulse = r_sec_pulse;
  assign min_pulse = r_min_pulse;
  assign day_pulse = r_day_pulse;
  assign load_err  = r_load_err;

endmodule

// File: tb/tb_bcd_timekeeper.sv
// tb/tb_bcd_timekeeper.sv - directed self-checking bench for bcd_timekeeper
module tb_bcd_timekeeper;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        load = 1'b0;
  logic [15:0] load_time = 16'h0000;
  logic        inc_min = 1'b0;
  logic        inc_hour = 1'b0;
  logic [15:0] cur_time;
  logic [7:0]  cur_sec;
  logic        sec_pulse;
  logic        min_pulse;
  logic        day_pulse;
  logic        load_err;

  int vectors = 0;
  int miscompares = 0;
  int n_sec, n_min, n_day, n_err, n_coinc;

  bcd_timekeeper #(.TICKS_PER_SEC(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .load      (load),
    .load_time (load_time),
    .inc_min   (inc_min),
    .inc_hour  (inc_hour),
    .cur_time  (cur_time),
    .cur_sec   (cur_sec),
    .sec_pulse (sec_pulse),
    .min_pulse (min_pulse),
    .day_pulse (day_pulse),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  task automatic clear_counts();
    n_sec = 0; n_min = 0; n_day = 0; n_err = 0; n_coinc = 0;
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sec_pulse) n_sec++;
      if (min_pulse) n_min++;
      if (day_pulse) n_day++;
      if (load_err) n_err++;
      if (sec_pulse && min_pulse && day_pulse) n_coinc++;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [15:0] t);
    load = 1'b1; load_time = t;
    tick(1);
    load = 1'b0;
  endtask

  initial begin
    // Reset dominates a concurrent load
    rst = 1'b0; load = 1'b1; load_time = 16'h1234;
    tick(2);
    check("rst_time", cur_time, 16'h0000);
    check("rst_sec", cur_sec, 8'h00);
    check("rst_pulses", {sec_pulse, min_pulse, day_pulse, load_err}, 4'h0);
    rst = 1'b1; load = 1'b0;

    // 12:59 + 60 s
    do_load(16'h1259);
    check("load_1259", cur_time, 16'h1259);
    clear_counts();
    run = 1'b1; tick(240); run = 1'b0;
    check("h1259_time", cur_time, 16'h1300);
    check("h1259_sec", cur_sec, 8'h00);
    check("h1259_nsec", n_sec, 60);
    check("h1259_nmin", n_min, 1);
    check("h1259_nday", n_day, 0);

    // 23:59 + 60 s -> midnight
    do_load(16'h2359);
    clear_counts();
    run = 1'b1; tick(240); run = 1'b0;
    check("h2359_time", cur_time, 16'h0000);
    check("h2359_coinc", n_coinc, 1);
    check("h2359_nday", n_day, 1);

    // Rejected loads while counting
    do_load(16'h0815);
    run = 1'b1; tick(3);
    clear_counts();
    do_load(16'h2460);
    check("err1_flag", load_err, 1'b1);
    check("err1_time", cur_time, 16'h0815);
    check("err1_sec", cur_sec, 8'h01);
    do_load(16'h12A0);
    check("err2_flag", load_err, 1'b1);
    tick(1);
    check("err_clear", load_err, 1'b0);
    tick(2);
    check("err_sec_count", cur_sec, 8'h02);
    check("err_time", cur_time, 16'h0815);
    check("err_count", n_err, 2);
    run = 1'b0;

    // Set buttons
    do_load(16'h1059);
    inc_min = 1'b1; tick(1); inc_min = 1'b0;
    check("inc_min_wrap", cur_time, 16'h1000);
    do_load(16'h2307);
    clear_counts();
    inc_hour = 1'b1; tick(1); inc_hour = 1'b0;
    check("inc_hour_wrap", cur_time, 16'h0007);
    check("inc_hour_noday", n_day, 0);
    do_load(16'h2359);
    clear_counts();
    inc_min = 1'b1; inc_hour = 1'b1; tick(1); inc_min = 1'b0; inc_hour = 1'b0;
    check("inc_both", cur_time, 16'h0000);
    check("inc_both_noday", n_day, 0);

    // Valid load beats a simultaneous increment
    load = 1'b1; load_time = 16'h0930; inc_min = 1'b1; tick(1);
    load = 1'b0; inc_min = 1'b0;
    check("load_beats_inc", cur_time, 16'h0930);
    // Invalid load lets the increment through
    load = 1'b1; load_time = 16'h1A00; inc_hour = 1'b1; tick(1);
    load = 1'b0; inc_hour = 1'b0;
    check("badload_inc", cur_time, 16'h1030);
    check("badload_inc_err", load_err, 1'b1);

    // inc_min on the seconds-wrap edge: carry dropped, single increment
    do_load(16'h1044);
    run = 1'b1; tick(239);
    check("pre_wrap_sec", cur_sec, 8'h59);
    check("pre_wrap_time", cur_time, 16'h1044);
    inc_min = 1'b1; tick(1); inc_min = 1'b0;
    check("coinc_time", cur_time, 16'h1045);
    check("coinc_sec", cur_sec, 8'h00);
    check("coinc_minp", min_pulse, 1'b1);

    // run=0 freezes prescaler and seconds
    tick(2);
    run = 1'b0;
    clear_counts();
    tick(20);
    check("frz_sec", cur_sec, 8'h00);
    check("frz_nsec", n_sec, 0);
    run = 1'b1; tick(1);
    check("frz_resume_hold", cur_sec, 8'h00);
    tick(1);
    check("frz_resume_tick", cur_sec, 8'h01);

    // Reset mid-second restarts the prescaler
    tick(2);
    rst = 1'b0; tick(1); rst = 1'b1;
    check("mid_rst_time", cur_time, 16'h0000);
    check("mid_rst_sec", cur_sec, 8'h00);
    clear_counts();
    tick(3);
    check("mid_rst_nopulse", n_sec, 0);
    tick(1);
    check("mid_rst_pulse", sec_pulse, 1'b1);
    check("mid_rst_sec1", cur_sec, 8'h01);
    run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd_timekeeper.md
Name: bcd_timekeeper

Overview:
Free-running 24-hour BCD time-of-day counter. It produces the HHMM word consumed by the alarm comparator as in_time, plus a BCD seconds field.
- Integer prescaler divides clk down to a 1 s tick.
- Supports direct time load and per-field manual increment for the set buttons.
- Emits one-cycle minute/day rollover strobes for downstream blocks (alarm, display refresh).

Parameters:
TICKS_PER_SEC, 100000000, clk cycles per second; must be >= 2.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-low reset
run  in  1  1 = timekeeping advances; 0 = prescaler and seconds frozen
load  in  1  one-cycle pulse: load load_time
load_time  in  16  BCD HHMM: [15:12]=H tens, [11:8]=H units, [7:4]=M tens, [3:0]=M units
inc_min  in  1  one-cycle pulse: minutes +1, no carry into hours
inc_hour  in  1  one-cycle pulse: hours +1
cur_time  out  16  BCD HHMM, registered
cur_sec  out  8  BCD seconds 00..59, registered
sec_pulse  out  1  high one cycle per elapsed second
min_pulse  out  1  high one cycle when seconds wrap 59->00 (natural minute rollover only)
day_pulse  out  1  high one cycle when time wraps 23:59:59 -> 00:00:00
load_err  out  1  high one cycle when a load is rejected

Behaviour:
- Reset, sampled on the rising clk edge while rst==0:
  - cur_time=16'h0000, cur_sec=8'h00, prescaler=0.
  - All pulse outputs 0.
  - rst dominates every other input, including mid-count and mid-load.
- All outputs are registered and change only on the rising edge.
- Prescaler: while run==1, counts 0..TICKS_PER_SEC-1.
  - At TICKS_PER_SEC-1 it wraps to 0. On that same edge sec_pulse=1 and seconds advance.
  - run==0 holds the prescaler and cur_sec, and the pulses stay 0.
- Seconds advance is BCD: units 9 -> 0 with a carry into tens; 59 -> 00 generates the minute carry.
- Minute carry:
  - Increments MM in BCD; 59 -> 00 generates the hour carry.
  - Hour carry increments HH; 23 -> 00 sets day_pulse.
  - The whole ripple completes in one edge, so 23:59:59 + tick gives 00:00:00 with sec_pulse, min_pulse and day_pulse all high on the same cycle.
- Load validity: every nibble <= 9, HH <= 23 and MM <= 59.
  - Valid load: cur_time <= load_time, cur_sec <= 00, prescaler <= 0, no pulses that cycle.
  - Invalid load (e.g. 16'h2460, 16'h1A00): load_err=1 for one cycle; time, seconds and prescaler are unaffected and continue normally.
- Priority per cycle: rst > valid load > manual increment > natural carry.
- inc_min:
  - Applied to MM: 59 -> 00, HH untouched.
  - Seconds and prescaler keep advancing normally that cycle.
  - Any natural minute carry arriving on the same edge is dropped. min_pulse still fires if seconds wrapped.
- inc_hour:
  - Applied to HH: 23 -> 00, no day_pulse.
  - A natural hour carry on the same edge is dropped.
- inc_min and inc_hour together: both fields increment independently on the same edge.
- load asserted together with inc_*: the load wins if valid. If it is invalid, the increments are applied and load_err is asserted.
- Manual increments and load work regardless of run.
- cur_time never holds a non-BCD or out-of-range value.

Decomposition:
- Shared package clock_pkg:
  - constants HOUR_MAX=8'h23, MIN_MAX=8'h59, SEC_MAX=8'h59, TIME_RESET=16'h0000
  - typedef for the 16-bit BCD HHMM word, reused by the alarm and display blocks
  - a validity function for the BCD HHMM word
- Sub-module bcd2_counter:
  - two-digit BCD counter with parameter MAX, ports inc, load, load_val, and outputs val, wrap
  - instantiated three times: seconds, minutes, hours
  - wrap is combinational (inc && val==MAX), used to build the carry chain
- Top level holds the prescaler, load validation, and priority/carry-suppression logic.

Test Plan:
- TICKS_PER_SEC=4. Hold rst=0 two cycles with load=1, load_time=16'h1234 -> cur_time=16'h0000, cur_sec=8'h00, all pulses 0.
- Load 16'h1259, run=1 for 240 cycles -> cur_time=16'h1300, cur_sec=00; exactly 60 sec_pulse and 1 min_pulse.
- Load 16'h2359, run 240 cycles -> cur_time=16'h0000; day_pulse, min_pulse and sec_pulse coincide on exactly one cycle.
- From 16'h0815, load 16'h2460, then 16'h12A0 -> load_err pulses once each; cur_time stays 16'h0815 and seconds keep counting.
- At 16'h1059, pulse inc_min -> 16'h1000. At 16'h2307, pulse inc_hour -> 16'h0007 with no day_pulse. Both together at 16'h2359 -> 16'h0000.
- Coincidence checks:
  - inc_min on the same edge as the seconds 59 -> 00 wrap at 16'h1044 -> cur_time=16'h1045 (carry dropped), min_pulse=1.
  - run=0 for 20 cycles -> cur_sec frozen and no sec_pulse.
  - rst=0 mid-second -> prescaler restarts from 0.
